counter_mod_updown: RTL and testbench



---
 rtl/counter_mod_updown.sv | 120 ++++++++++++
 tb/tb_counter_mod_updown.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_mod_updown.sv
// counter_mod_updown: parametrised modulo-MOD up/down counter with
// synchronous load (clamped to MOD-1), enable, one-shot stop with a
// sticky done flag, and a combinational carry/borrow (c_out) that can
// drive the enable of the next digit in a cascade.
//
// Optional feature macro: COUNTER_MOD_MATCH_EN
//   When defined, adds input match_val and a registered one-cycle match
//   pulse raised after any edge where count takes the value match_val
//   by a load or a step. Undefined: no ports and no compare logic.
//
// Parameters: WIDTH 1..16, MOD 2..2**WIDTH, RESET_VAL < MOD.
module counter_mod_updown #(
  parameter int WIDTH     = 4,
  parameter int MOD       = 10,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_in,
  input  logic             up,
  input  logic             one_shot,
`ifdef COUNTER_MOD_MATCH_EN
  input  logic [WIDTH-1:0] match_val,
  output logic             match,
`endif
  output logic [WIDTH-1:0] count,
  output logic             c_out,
  output logic             done
);

  // The modulus may equal 2**WIDTH, so the clamp compare is done one bit wider.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_reg, count_next;
  logic             done_reg, done_next;
  logic             at_term;
  logic             step_go;
  logic             stop_hit;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] step_val;

  // Terminal detect, clamped load value, and the wrapped next step value.
  always_comb begin
    at_term  = up ? (count_reg == MAX_VAL) : (count_reg == '0);
    load_val = ({1'b0, load_in} < MOD_EXT) ? load_in : MAX_VAL;
    if (up) begin
      step_val = at_term ? '0 : count_reg + WIDTH'(1);
    end else begin
      step_val = at_term ? MAX_VAL : count_reg - WIDTH'(1);
    end
    // A step only happens when not loading and not latched done.
    step_go  = enable & ~load & ~done_reg;
    stop_hit = step_go & one_shot & at_term;
  end

  // Next-state selection: load beats step; one-shot stop sets done instead of wrapping.
  always_comb begin
    count_next = count_reg;
    done_next  = done_reg;
    if (load) begin
      count_next = load_val;
      done_next  = 1'b0;
    end else if (step_go) begin
      if (stop_hit) begin
        done_next = 1'b1;
      end else begin
        count_next = step_val;
      end
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= RST_VAL;
      done_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      done_reg  <= done_next;
    end
  end

  // Carry/borrow fires on the wrap or stop edge, including the one-shot stop.
  always_comb begin
    c_out = step_go & ~reset & at_term;
  end

  assign count = count_reg;
  assign done  = done_reg;

`ifdef COUNTER_MOD_MATCH_EN
  logic match_reg, match_next;

  // Pulse only when count is written by a load or a real step, never on hold.
  always_comb begin
    match_next = 1'b0;
    if (load) begin
      match_next = (load_val == match_val);
    end else if (step_go && !stop_hit) begin
      match_next = (step_val == match_val);
    end
  end

  // Registered match flag, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      match_reg <= 1'b0;
    end else begin
      match_reg <= match_next;
    end
  end

  assign match = match_reg;
`endif

endmodule

// File: tb/tb_counter_mod_updown.sv
// Testbench for counter_mod_updown: table-driven vectors, randomized
// stimulus against a modular-arithmetic reference model, a two-digit
// cascade, and (with COUNTER_MOD_MATCH_EN) a match pulse sequence.
module tb_counter_mod_updown;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the two single-digit instances.
  logic       reset = 1'b0, enable = 1'b0, load = 1'b0, up = 1'b1, one_shot = 1'b0;
  logic [3:0] load_in = '0;
  logic [3:0] count_a, count_b;
  logic       c_out_a, c_out_b, done_a, done_b;
  logic [3:0] match_val = 4'd5;
  logic       match_a, match_b;

  // Cascade signals.
  logic       cas_reset = 1'b0, cas_en = 1'b1, cas_load = 1'b0, cas_up = 1'b1, cas_os = 1'b0;
  logic [3:0] cas_li = '0;
  logic [3:0] u_count, t_count;
  logic       u_c, t_c, u_done, t_done, u_match, t_match;

  counter_mod_updown #(.WIDTH(4), .MOD(10), .RESET_VAL(0)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .load_in(load_in),
    .up(up), .one_shot(one_shot),
`ifdef COUNTER_MOD_MATCH_EN
    .match_val(match_val), .match(match_a),
`endif
    .count(count_a), .c_out(c_out_a), .done(done_a));

  counter_mod_updown #(.WIDTH(4), .MOD(16), .RESET_VAL(3)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .load_in(load_in),
    .up(up), .one_shot(one_shot),
`ifdef COUNTER_MOD_MATCH_EN
    .match_val(match_val), .match(match_b),
`endif
    .count(count_b), .c_out(c_out_b), .done(done_b));

  counter_mod_updown #(.WIDTH(4), .MOD(10), .RESET_VAL(0)) u_units (
    .clk(clk), .reset(cas_reset), .enable(cas_en), .load(cas_load), .load_in(cas_li),
    .up(cas_up), .one_shot(cas_os),
`ifdef COUNTER_MOD_MATCH_EN
    .match_val(match_val), .match(u_match),
`endif
    .count(u_count), .c_out(u_c), .done(u_done));

  counter_mod_updown #(.WIDTH(4), .MOD(10), .RESET_VAL(0)) u_tens (
    .clk(clk), .reset(cas_reset), .enable(u_c), .load(cas_load), .load_in(cas_li),
    .up(cas_up), .one_shot(cas_os),
`ifdef COUNTER_MOD_MATCH_EN
    .match_val(match_val), .match(t_match),
`endif
    .count(t_count), .c_out(t_c), .done(t_done));

`ifndef COUNTER_MOD_MATCH_EN
  assign match_a = 1'b0;
  assign match_b = 1'b0;
  assign u_match = 1'b0;
  assign t_match = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: index 0 = MOD 10 / reset 0, index 1 = MOD 16 / reset 3.
  int mods[2] = '{10, 16};
  int rvals[2] = '{0, 3};
  int m_cnt[2] = '{0, 0};
  int m_done[2] = '{0, 0};

  function automatic int model_term(input int k, input logic u);
    return u ? mods[k] - 1 : 0;
  endfunction

  function automatic int model_cout(input int k, input logic r, input logic l,
                                    input logic e, input logic u);
    return (!r && !l && e && m_done[k] == 0 && m_cnt[k] == model_term(k, u)) ? 1 : 0;
  endfunction

  task automatic model_step(input int k, input logic r, input logic l, input logic e,
                            input logic u, input logic os, input int li);
    if (r) begin
      m_cnt[k] = rvals[k];
      m_done[k] = 0;
    end else if (l) begin
      m_cnt[k] = (li < mods[k]) ? li : mods[k] - 1;
      m_done[k] = 0;
    end else if (e && m_done[k] == 0) begin
      if (os && m_cnt[k] == model_term(k, u)) m_done[k] = 1;
      else if (u) m_cnt[k] = (m_cnt[k] + 1) % mods[k];
      else m_cnt[k] = (m_cnt[k] + mods[k] - 1) % mods[k];
    end
  endtask

  typedef struct {
    logic rst, ld, en, u, os;
    int   li;
    int   exp_c;
    int   exp_cnt;
    int   exp_done;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rst, input logic ld, input logic en, input logic u,
                              input logic os, input int li, input int c, input int cnt,
                              input int d);
    vec_t v;
    v.rst = rst; v.ld = ld; v.en = en; v.u = u; v.os = os; v.li = li;
    v.exp_c = c; v.exp_cnt = cnt; v.exp_done = d;
    tbl.push_back(v);
  endfunction

  // One clock transaction on the shared inputs; checks both DUTs against the
  // model, and dut_a against the table row when has_exp is set.
  task automatic run_vec(input vec_t v, input bit has_exp, input string tag);
    int mc[2];
    @(negedge clk);
    reset = v.rst; load = v.ld; enable = v.en; up = v.u; one_shot = v.os;
    load_in = 4'(v.li);
    #1;
    for (int k = 0; k < 2; k++) mc[k] = model_cout(k, v.rst, v.ld, v.en, v.u);
    check({tag, ".a.c_out"}, int'(c_out_a), mc[0]);
    check({tag, ".b.c_out"}, int'(c_out_b), mc[1]);
    if (has_exp) check({tag, ".tbl.c_out"}, int'(c_out_a), v.exp_c);
    for (int k = 0; k < 2; k++) model_step(k, v.rst, v.ld, v.en, v.u, v.os, v.li);
    @(posedge clk);
    #1;
    check({tag, ".a.count"}, int'(count_a), m_cnt[0]);
    check({tag, ".a.done"}, int'(done_a), m_done[0]);
    check({tag, ".b.count"}, int'(count_b), m_cnt[1]);
    check({tag, ".b.done"}, int'(done_b), m_done[1]);
    if (has_exp) begin
      check({tag, ".tbl.count"}, int'(count_a), v.exp_cnt);
      check({tag, ".tbl.done"}, int'(done_a), v.exp_done);
    end
    $display("%s rst=%0b ld=%0b en=%0b up=%0b os=%0b li=%0d | a: cnt=%0d c=%0b d=%0b | b: cnt=%0d c=%0b d=%0b",
             tag, v.rst, v.ld, v.en, v.u, v.os, v.li, count_a, c_out_a, done_a,
             count_b, c_out_b, done_b);
  endtask

  initial begin
    vec_t v;

    // Reset state.
    add(1, 0, 1, 1, 0, 0, 0, 0, 0);
    // Wrap up for 12 steps from 0.
    for (int i = 0; i < 12; i++) add(0, 0, 1, 1, 0, 0, (i % 10 == 9) ? 1 : 0, (i + 1) % 10, 0);
    // Wrap down from 2: borrow while count is 0.
    add(0, 0, 1, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 9, 0);
    add(0, 0, 1, 0, 0, 0, 0, 8, 0);
    // Clamp loads; load with enable at terminal suppresses c_out.
    add(0, 1, 0, 0, 0, 13, 0, 9, 0);
    add(0, 1, 1, 1, 0, 10, 0, 9, 0);
    add(0, 1, 0, 1, 0, 15, 0, 9, 0);
    // One-shot up from 7.
    add(0, 1, 0, 1, 1, 7, 0, 7, 0);
    add(0, 0, 1, 1, 1, 0, 0, 8, 0);
    add(0, 0, 1, 1, 1, 0, 0, 9, 0);
    add(0, 0, 1, 1, 1, 0, 1, 9, 1);
    add(0, 0, 1, 1, 1, 0, 0, 9, 1);
    add(0, 0, 1, 0, 0, 0, 0, 9, 1);
    add(0, 0, 0, 1, 0, 0, 0, 9, 1);
    // Load clears done; one-shot down stops at 0.
    add(0, 1, 0, 0, 1, 1, 0, 1, 0);
    add(0, 0, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0, 1, 0, 1);
    // Priority: reset over load and enable; load over enable.
    add(1, 1, 1, 1, 0, 5, 0, 0, 0);
    add(0, 1, 1, 1, 0, 4, 0, 4, 0);
    // Direction change mid-count.
    add(0, 1, 0, 1, 0, 9, 0, 9, 0);
    add(0, 0, 1, 0, 0, 0, 0, 8, 0);
    add(0, 0, 1, 1, 0, 0, 0, 9, 0);
    add(0, 0, 1, 1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) run_vec(tbl[i], 1'b1, $sformatf("tbl%0d", i));

`ifdef COUNTER_MOD_MATCH_EN
    // Match pulse: count up from 0 to 5, then hold.
    v.rst = 1; v.ld = 0; v.en = 0; v.u = 1; v.os = 0; v.li = 0;
    v.exp_c = 0; v.exp_cnt = 0; v.exp_done = 0;
    run_vec(v, 1'b0, "mrst");
    check("match.reset", int'(match_a), 0);
    v.rst = 0; v.en = 1;
    for (int i = 1; i <= 5; i++) begin
      run_vec(v, 1'b0, $sformatf("mup%0d", i));
      check($sformatf("match.up%0d", i), int'(match_a), (i == 5) ? 1 : 0);
    end
    v.en = 0;
    for (int i = 0; i < 2; i++) begin
      run_vec(v, 1'b0, $sformatf("mhold%0d", i));
      check($sformatf("match.hold%0d", i), int'(match_a), 0);
    end
    v.ld = 1; v.li = 5;
    run_vec(v, 1'b0, "mload");
    check("match.load", int'(match_a), 1);
`endif

    // Randomized stimulus against the model.
    for (int i = 0; i < 400; i++) begin
      v.rst = ($urandom_range(0, 31) == 0);
      v.ld  = ($urandom_range(0, 7) == 0);
      v.en  = ($urandom_range(0, 3) != 0);
      v.u   = 1'($urandom_range(0, 1));
      v.os  = ($urandom_range(0, 3) == 0);
      v.li  = $urandom_range(0, 15);
      v.exp_c = 0; v.exp_cnt = 0; v.exp_done = 0;
      run_vec(v, 1'b0, $sformatf("rnd%0d", i));
    end

    // Two-digit cascade: 100 free-running steps from 00 back to 00.
    @(negedge clk);
    cas_reset = 1'b1;
    @(posedge clk);
    #1;
    check("cas.reset.units", int'(u_count), 0);
    check("cas.reset.tens", int'(t_count), 0);
    @(negedge clk);
    cas_reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      check($sformatf("cas%0d.units_c", i), int'(u_c), (i % 10 == 9) ? 1 : 0);
      @(posedge clk);
      #1;
      check($sformatf("cas%0d.units", i), int'(u_count), (i + 1) % 10);
      check($sformatf("cas%0d.tens", i), int'(t_count), ((i + 1) / 10) % 10);
      $display("cas%0d tens=%0d units=%0d", i, t_count, u_count);
      @(negedge clk);
    end
    check("cas.final.units", int'(u_count), 0);
    check("cas.final.tens", int'(t_count), 0);
    check("cas.done", int'(u_done | t_done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
